uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and bit-timing derivation.
// UART_RX_PARITY_EN adds the PARITY state for even-parity frames.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_state_e;

    // Clocks per serial bit; callers must keep CLK_FREQ/BAUD at 4 or more.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the idle-high serial line; both flops reset to 1
// so that leaving reset never looks like a start-bit edge.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined), sampled at
// bit centres, with a sticky framing-error flag and a sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic       rdy,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 accept_q, accept_d;
    logic                 frame_set;
    logic                 overrun_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            accept_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            accept_q  <= accept_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        accept_d  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rxs) state_d = START;
            end

            START: begin
                // A line that is high again at mid start bit was a glitch.
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    state_d   = rxs ? IDLE : DATA;
                end
            end

            DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    par_bad_d = (even_parity(shift_q) != rxs);
                    state_d   = STOP;
                end
            end
`endif

            STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        frame_set = par_bad_q;
                        accept_d  = !par_bad_q;
`else
                        accept_d  = 1'b1;
`endif
                    end else begin
                        // Stop bit low: possibly a break, so wait for the line to recover.
                        frame_set = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                clk_cnt_d = '0;
                if (rxs) state_d = IDLE;
            end

            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // A byte arriving while the previous one is unread is dropped, unless the
    // read happens in the very same cycle.
    assign overrun_set = accept_q && rdy && !rdy_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept_q && !overrun_set) begin
                dout <= shift_q;
                rdy  <= 1'b1;
            end else if (rdy_clr) begin
                rdy  <= 1'b0;
            end

            if (frame_set)    frame_err <= 1'b1;
            else if (rdy_clr) frame_err <= 1'b0;

            if (overrun_set)  overrun <= 1'b1;
            else if (rdy_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; the expected flags and
// data come from a frame-level model (good frame / bad frame / read strobe).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    // Line edge to acceptance: 2 synchroniser clocks, 1 clock to leave IDLE,
    // half a bit, the remaining bit periods up to the stop sample, 1 clock to register.
    localparam int ACCEPT_EDGE = 3 + HALF + CPB * (NBITS - 1) + 1;
    localparam int STOP_CENTRE = CPB * (NBITS - 1) + HALF;
    localparam int GAP         = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rdy_clr;
    logic       rdy;
    logic [7:0] dout;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_dout;
    logic       m_rdy, m_ferr, m_ovr;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .rdy       (rdy),
        .dout      (dout),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_rdy"},       32'(rdy),       32'(m_rdy));
        check({tag, "_dout"},      32'(dout),      32'(m_dout));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_overrun"},   32'(overrun),   32'(m_ovr));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_pulse();
        rdy_clr = 1'b1;
        tick(1);
        rdy_clr = 1'b0;
        m_rdy  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    function automatic logic par_of(input logic [7:0] d);
        return ^d;
    endfunction

    // Drives one whole frame, optionally strobing rdy_clr on the acceptance
    // cycle, then updates the model with the frame's outcome.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_val,
                              input logic clr_at_acc, input int low_hold, output int rdy_edge);
        logic [10:0] bits;
        logic        was_rdy;
        logic        good;
`ifdef UART_RX_PARITY_EN
        bits = {stop_val, par_val, data, 1'b0};
        good = stop_val && (par_val == par_of(data));
`else
        // Bit 10 lies past the stop bit and is never driven in this frame format.
        bits = {par_val, stop_val, data, 1'b0};
        good = stop_val;
`endif
        was_rdy  = rdy;
        rdy_edge = -1;
        for (int i = 0; i < NBITS * CPB; i++) begin
            rx      = bits[i / CPB];
            rdy_clr = clr_at_acc && (i == ACCEPT_EDGE - 1);
            tick(1);
            if (!was_rdy && rdy && rdy_edge < 0) rdy_edge = i + 1;
        end
        rdy_clr = 1'b0;
        if (!stop_val) tick(low_hold);
        rx = 1'b1;
        tick(GAP);

        if (!good) begin
            m_ferr = 1'b1;
        end else if (m_rdy && !clr_at_acc) begin
            m_ovr = 1'b1;
        end else begin
            m_dout = data;
            m_rdy  = 1'b1;
            if (clr_at_acc) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
        end
    endtask

    initial begin
        int         e;
        logic [7:0] d;
        logic       stop_v, par_v, good, clr_a;

        rx = 1'b1;
        rdy_clr = 1'b0;
        rst_n = 1'b0;
        m_dout = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        tick(3);
        compare_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Clean frame, acceptance latency, then read strobe.
        send_frame(8'hA5, 1'b1, par_of(8'hA5), 1'b0, 0, e);
        compare_outputs("a5");
        check("a5_rdy_latency", 32'((e > STOP_CENTRE) && (e <= STOP_CENTRE + 4)), 32'd1);
        clear_pulse();
        compare_outputs("a5_clr");

        // Short low glitch is ignored.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        compare_outputs("glitch");
        check("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Stop bit low with the line held low 40 clocks, then recovery.
        send_frame(8'h3C, 1'b0, par_of(8'h3C), 1'b0, 40 - CPB, e);
        compare_outputs("ferr");
        send_frame(8'h11, 1'b1, par_of(8'h11), 1'b0, 0, e);
        compare_outputs("after_ferr");
        clear_pulse();

        // Overrun, then acceptance coinciding with the read strobe.
        send_frame(8'h12, 1'b1, par_of(8'h12), 1'b0, 0, e);
        send_frame(8'h34, 1'b1, par_of(8'h34), 1'b0, 0, e);
        compare_outputs("overrun");
        clear_pulse();
        send_frame(8'h12, 1'b1, par_of(8'h12), 1'b0, 0, e);
        send_frame(8'h34, 1'b1, par_of(8'h34), 1'b1, 0, e);
        compare_outputs("clr_on_accept");
        send_frame(8'h77, 1'b1, par_of(8'h77), 1'b0, 0, e);
        compare_outputs("overrun2");

        // Reset in the middle of a 0xFF frame, during data bit 4.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB);
        rst_n = 1'b0;
        #1;
        m_dout = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        compare_outputs("mid_reset");
        tick(3);
        rst_n = 1'b1;
        tick(5 * CPB);
        send_frame(8'h5A, 1'b1, par_of(8'h5A), 1'b0, 0, e);
        compare_outputs("after_reset");

`ifdef UART_RX_PARITY_EN
        clear_pulse();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, e);
        compare_outputs("par_ok");
        clear_pulse();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0, e);
        compare_outputs("par_bad");
`endif

        // Randomised frames, reads and line faults.
        for (int k = 0; k < 24; k++) begin
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 9) != 0);
            par_v  = par_of(d);
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 9) == 0) par_v = ~par_v;
            good = stop_v && (par_v == par_of(d));
`else
            good = stop_v;
`endif
            if ($urandom_range(0, 2) == 0) clear_pulse();
            clr_a = good && ($urandom_range(0, 3) == 0);
            send_frame(d, stop_v, par_v, clr_a, int'($urandom_range(0, 40)), e);
            compare_outputs($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
